// File: rtl/if_table_scheduler.sv
// Port-A scheduler for the IF-circuit lookup-table RAM: round-robin lookups
// from the channel front ends interleaved with host table (re)loading.
module if_table_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      ld_valid,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      ld_last,
  output logic                      ld_ready,
  output logic                      tbl_ready,
  output logic [ADDR_W:0]           ld_count,
  output logic [ADDR_W-1:0]         tbl_addr,
  output logic                      tbl_en,
  output logic                      tbl_we,
  output logic [DATA_W-1:0]         tbl_din,
  input  logic [DATA_W-1:0]         tbl_dout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NREQ    = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(NUM_REQ - 1);
  localparam logic [ADDR_W:0]  CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, idx, rd_win;
  logic [IDX_W:0]     cand;
  logic               rd_found, read_ok, grant_wr, grant_rd, arb;
  logic               last_wr, last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    rd_found = 1'b0;
    rd_win   = ptr;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!rd_found && req_valid[cand[IDX_W-1:0]]) begin
        rd_found = 1'b1;
        rd_win   = cand[IDX_W-1:0];
      end
    end
  end

  // A write yields to a pending eligible read only right after another write.
  assign arb      = (state == IDLE) || (state == CAP);
  assign read_ok  = tbl_ready && rd_found;
  assign grant_wr = ld_valid && !(last_wr && read_ok);
  assign grant_rd = read_ok && !grant_wr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, CAP: begin
        if (grant_wr)      state_nxt = WR;
        else if (grant_rd) state_nxt = RD;
        else               state_nxt = IDLE;
      end
      RD:      state_nxt = CAP;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      last_wr   <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      tbl_ready <= 1'b0;
      ld_count  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      if (state == CAP) begin
        rsp_valid <= NUM_REQ'(1) << idx;
        rsp_data  <= tbl_dout;
      end
      if (arb && grant_wr) begin
        addr_q  <= ld_addr;
        din_q   <= ld_data;
        last_q  <= ld_last;
        last_wr <= 1'b1;
      end else if (arb && grant_rd) begin
        addr_q  <= addr_arr[rd_win];
        idx     <= rd_win;
        ptr     <= (rd_win == LAST_IX) ? '0 : rd_win + 1'b1;
        last_wr <= 1'b0;
      end
      // Any non-final write invalidates the resident table until ld_last.
      if (state == WR) begin
        if (last_q) begin
          tbl_ready <= 1'b1;
          ld_count  <= '0;
        end else begin
          tbl_ready <= 1'b0;
          if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
        end
      end
    end
  end

  assign req_ready = (state == RD) ? (NUM_REQ'(1) << idx) : '0;
  assign ld_ready  = (state == WR);
  assign tbl_en    = (state == RD) || (state == WR);
  assign tbl_we    = (state == WR);
  assign tbl_addr  = addr_q;
  assign tbl_din   = din_q;

endmodule

// File: tb/tb_if_table_scheduler.sv
// Directed self-checking bench for if_table_scheduler with a behavioural
// 4096x12 RAM (1-cycle registered read) attached to port A.
module tb_if_table_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 12;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      ld_valid;
  logic [ADDR_W-1:0]         ld_addr;
  logic [DATA_W-1:0]         ld_data;
  logic                      ld_last;
  logic                      ld_ready;
  logic                      tbl_ready;
  logic [ADDR_W:0]           ld_count;
  logic [ADDR_W-1:0]         tbl_addr;
  logic                      tbl_en;
  logic                      tbl_we;
  logic [DATA_W-1:0]         tbl_din;
  logic [DATA_W-1:0]         tbl_dout;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [4096];

  if_table_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .tbl_ready(tbl_ready), .ld_count(ld_count),
    .tbl_addr(tbl_addr), .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_din(tbl_din),
    .tbl_dout(tbl_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_din;
      else        tbl_dout <= mem[tbl_addr];
    end
  end

  // Streams n words (data = addr ^ 0xA5A), waiting for each ld_ready pulse.
  task automatic load_words(input int start, input int n, input bit last_final,
                            output int pulses, output bit timeout);
    bit got;
    pulses  = 0;
    timeout = 0;
    for (int i = 0; i < n && !timeout; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 12'(start + i);
      ld_data  = 12'(start + i) ^ 12'hA5A;
      ld_last  = last_final && (i == n - 1);
      got = 0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (ld_ready) got = 1;
      end
      if (got) pulses++;
      else     timeout = 1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0; req_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, ld_ready, tbl_ready, ld_count, tbl_en, tbl_we, tbl_addr, tbl_din} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rsp_valid=%b req_ready=%b tbl_ready=%b ld_count=%0d tbl_en=%b, required all 0",
               rsp_valid, req_ready, tbl_ready, ld_count, tbl_en);
    end
  endtask

  task automatic test_blocked_lookup;
    int bad;
    bad = 0;
    req_addr[0 +: ADDR_W] = 12'h010;
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || tbl_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL blocked_lookup: %0d cycles with req_ready/tbl_en active, required 0", bad);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_full_load;
    int p1, p2;
    bit to1, to2;
    load_words(0, 4095, 1'b0, p1, to1);
    checks++;
    if (tbl_ready !== 1'b0 || ld_count !== 13'd4095) begin
      errors++;
      $display("[TB] FAIL load_partial: tbl_ready=%b ld_count=%0d, required 0 and 4095", tbl_ready, ld_count);
    end
    load_words(4095, 1, 1'b1, p2, to2);
    checks++;
    if (to1 || to2 || (p1 + p2) != 4096) begin
      errors++;
      $display("[TB] FAIL load_pulses: got %0d ld_ready pulses (timeout=%b), required 4096", p1 + p2, to1 | to2);
    end
    checks++;
    if (tbl_ready !== 1'b1 || ld_count !== 13'd0) begin
      errors++;
      $display("[TB] FAIL load_done: tbl_ready=%b ld_count=%0d, required 1 and 0", tbl_ready, ld_count);
    end
  endtask

  task automatic test_single_lookup;
    logic [DATA_W-1:0] exp_d;
    exp_d = 12'h123 ^ 12'hA5A;
    req_addr[2*ADDR_W +: ADDR_W] = 12'h123;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_accept: req_ready=%b, required 0100", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_early_rsp: rsp_valid=%b, required 0000", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== exp_d) begin
      errors++;
      $display("[TB] FAIL single_rsp: rsp_valid=%b rsp_data=%h, required 0100 and %h", rsp_valid, rsp_data, exp_d);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int g[8];
    int r_idx[8];
    int r_cyc[8];
    logic [DATA_W-1:0] r_dat[8];
    int ng, nr;
    int exp_g[5];
    exp_g = '{3, 0, 1, 2, 3};
    ng = 0; nr = 0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 12'(i);
    req_valid = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && ng < 8) begin g[ng] = i; ng++; end
        if (rsp_valid[i] && nr < 8) begin r_idx[nr] = i; r_dat[nr] = rsp_data; r_cyc[nr] = c; nr++; end
      end
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ng != 5 || nr != 4) begin
      errors++;
      $display("[TB] FAIL b2b_counts: grants=%0d responses=%0d, required 5 and 4", ng, nr);
    end
    for (int k = 0; k < 5 && k < ng; k++) begin
      checks++;
      if (g[k] != exp_g[k]) begin
        errors++;
        $display("[TB] FAIL b2b_grant[%0d]: requester %0d, required %0d", k, g[k], exp_g[k]);
      end
    end
    for (int k = 0; k < 4 && k < nr; k++) begin
      checks++;
      if (r_idx[k] != exp_g[k] || r_dat[k] !== (12'(exp_g[k]) ^ 12'hA5A)) begin
        errors++;
        $display("[TB] FAIL b2b_rsp[%0d]: idx=%0d data=%h, required idx=%0d data=%h",
                 k, r_idx[k], r_dat[k], exp_g[k], 12'(exp_g[k]) ^ 12'hA5A);
      end
      if (k > 0) begin
        checks++;
        if (r_cyc[k] - r_cyc[k-1] != 2) begin
          errors++;
          $display("[TB] FAIL b2b_spacing[%0d]: %0d cycles, required 2", k, r_cyc[k] - r_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_load_read_alternate;
    string ev;
    int wi;
    int rsp_seen;
    logic [DATA_W-1:0] rsp_val;
    ev = "";
    wi = 0;
    rsp_seen = 0;
    rsp_val = '0;
    req_addr[1*ADDR_W +: ADDR_W] = 12'h001;
    req_valid = 4'b0010;
    ld_valid = 1'b1; ld_addr = 12'h010; ld_data = 12'h010 ^ 12'hA5A; ld_last = 1'b0;
    for (int c = 0; c < 40 && ev.len() < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin rsp_seen++; rsp_val = rsp_data; end
      if (req_ready[1]) ev = {ev, "R"};
      if (ld_ready) begin
        ev = {ev, "W"};
        wi++;
        if (wi < 4) begin
          ld_addr = 12'(16 + wi);
          ld_data = 12'(16 + wi) ^ 12'hA5A;
          ld_last = (wi == 1) || (wi == 3);
        end else begin
          ld_valid = 1'b0;
          ld_last  = 1'b0;
        end
      end
    end
    req_valid = '0;
    ld_valid  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ev != "WWRWWR") begin
      errors++;
      $display("[TB] FAIL alternate_order: events %s, required WWRWWR", ev);
    end
    checks++;
    if (rsp_seen < 1 || rsp_val !== 12'hA5B) begin
      errors++;
      $display("[TB] FAIL alternate_rsp: %0d responses data=%h, required >=1 and a5b", rsp_seen, rsp_val);
    end
    checks++;
    if (tbl_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alternate_tbl_ready: tbl_ready=%b, required 1", tbl_ready);
    end
  endtask

  task automatic test_reset_during_cap;
    int bad;
    bad = 0;
    req_addr[0 +: ADDR_W] = 12'h005;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL cap_reset_accept: req_ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, ld_ready, tbl_ready, ld_count, tbl_en, tbl_we, tbl_addr, tbl_din} !== '0) begin
      errors++;
      $display("[TB] FAIL cap_reset_outputs: rsp_valid=%b tbl_ready=%b ld_count=%0d tbl_en=%b tbl_addr=%h, required all 0",
               rsp_valid, tbl_ready, ld_count, tbl_en, tbl_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || tbl_ready !== 1'b0 || ld_count !== 13'd0) begin
      errors++;
      $display("[TB] FAIL cap_reset_after: stray rsp cycles=%0d tbl_ready=%b ld_count=%0d, required 0/0/0",
               bad, tbl_ready, ld_count);
    end
  endtask

  task automatic test_count_saturate;
    int p;
    bit to;
    load_words(0, 4097, 1'b0, p, to);
    checks++;
    if (to || p != 4097 || ld_count !== 13'd4096 || tbl_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL count_saturate: pulses=%0d timeout=%b ld_count=%0d tbl_ready=%b, required 4097/0/4096/0",
               p, to, ld_count, tbl_ready);
    end
  endtask

  initial begin
    test_reset;
    test_blocked_lookup;
    test_full_load;
    test_single_lookup;
    test_back_to_back;
    test_load_read_alternate;
    test_reset_during_cap;
    test_count_saturate;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
